prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/prog_loader_if.sv | 21 ++
 rtl/prog_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction geometry, opcode constants and the
// program-loader state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W    = 19;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned IMEM_DEPTH = 255;

  // Opcodes carried in instr[18:16]
  localparam logic [2:0] LD  = 3'd0;
  localparam logic [2:0] ADD = 3'd1;
  localparam logic [2:0] SUB = 3'd2;
  localparam logic [2:0] JZ  = 3'd3;
  localparam logic [2:0] JNZ = 3'd4;
  localparam logic [2:0] J   = 3'd5;
  localparam logic [2:0] ST  = 3'd6;
  localparam logic [2:0] STR = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    B0,
    B1,
    B2,
    WR,
    DONE
  } ld_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Loader byte stream (valid/ready) plus instruction-memory write port.
interface prog_loader_if #(
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
);
  logic [7:0]                  in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic                        imem_we;
  logic [cpu_pkg::ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0]          imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses a header byte N followed by N three-byte
// instructions and writes them to instruction memory at addresses 0..N-1,
// then releases the CPU via cpu_run.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W    = cpu_pkg::INSTR_W,
  parameter int unsigned IMEM_DEPTH = cpu_pkg::IMEM_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  prog_loader_if.slave    bus,
  output logic            cpu_run,
  output logic            busy,
  output logic            err
);

  ld_state_t           state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          count_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                err_q;
  logic                ready;
  logic                accept;
  logic                hdr_bad;

  assign accept  = bus.in_valid & ready;
  // A header equal to the memory depth (0xFF at default) is rejected, so the
  // address counter can never step past the last writable word.
  assign hdr_bad = 32'(bus.in_data) >= IMEM_DEPTH;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake decode
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: state_d = HDR;
      HDR: begin
        ready = 1'b1;
        if (accept) begin
          if (bus.in_data == 8'd0) state_d = DONE;
          else if (!hdr_bad)       state_d = B0;
        end
      end
      B0: begin
        ready = 1'b1;
        if (accept) state_d = B1;
      end
      B1: begin
        ready = 1'b1;
        if (accept) state_d = B2;
      end
      B2: begin
        ready = 1'b1;
        if (accept) state_d = WR;
      end
      WR:      state_d = (count_q == 8'd1) ? DONE : B0;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: count/address tracking, instruction assembly, sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        HDR: if (accept) begin
          if (hdr_bad) begin
            err_q <= 1'b1;
          end else if (bus.in_data != 8'd0) begin
            count_q <= bus.in_data;
            addr_q  <= '0;
          end
        end
        B0: if (accept) begin
          instr_q[18:16] <= bus.in_data[2:0];
          if (|bus.in_data[7:3]) err_q <= 1'b1;
        end
        B1: if (accept) instr_q[15:8] <= bus.in_data;
        B2: if (accept) instr_q[7:0]  <= bus.in_data;
        WR: begin
          addr_q  <= addr_q + ADDR_W'(1);
          count_q <= count_q - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = ready;
  assign bus.imem_we    = (state_q == WR);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = instr_q;
  assign cpu_run        = (state_q == DONE);
  assign busy           = (state_q == B0) || (state_q == B1) ||
                          (state_q == B2) || (state_q == WR);
  assign err            = err_q;

endmodule
